// File: rtl/parity_checker.sv
// Receive-side parity checker: recomputes parity on each accepted word and registers
// the word with its error flag, plus a sticky error flag and a saturating error count.
module parity_checker #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = 0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   parity_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   parity_err,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   err_sticky,
    output logic [COUNT_WIDTH-1:0] err_count,
    input  logic                   clr_count
);

    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_err;
    logic                   r_valid;
    logic                   r_sticky;
    logic [COUNT_WIDTH-1:0] r_count;

    logic w_p_exp;
    logic w_err;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_p_exp    = (PARITY_TYPE != 0) ? ~^data_in : ^data_in;
    assign w_err      = parity_in ^ w_p_exp;
    // Only combinational path through the block: ready_in -> ready_out.
    assign ready_out  = !r_valid || ready_in;
    assign w_in_xfer  = valid_in && ready_out;
    assign w_out_xfer = r_valid && ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_data  <= data_in;
            r_err   <= w_err;
            r_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle errored word, which is then not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (clr_count) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (w_in_xfer && w_err) begin
            r_sticky <= 1'b1;
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign parity_err = r_err;
    assign valid_out  = r_valid;
    assign err_sticky = r_sticky;
    assign err_count  = r_count;

endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: an even/8-bit-count and an odd/2-bit-count instance share
// stimulus; directed cases plus random traffic are compared against a behavioural model.
module tb_parity_checker;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       parity_in;
    logic       valid_in;
    logic       ready_in;
    logic       clr_count;

    logic       a_ready_out, a_parity_err, a_valid_out, a_err_sticky;
    logic [7:0] a_data_out;
    logic [7:0] a_err_count;
    logic       b_ready_out, b_parity_err, b_valid_out, b_err_sticky;
    logic [7:0] b_data_out;
    logic [1:0] b_err_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = even/COUNT_WIDTH 8, index 1 = odd/COUNT_WIDTH 2
    bit       m_valid  [2];
    bit [7:0] m_data   [2];
    bit       m_err    [2];
    int       m_cnt    [2];
    bit       m_sticky [2];
    int       PT   [2] = '{0, 1};
    int       CMAX [2] = '{255, 3};

    parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(0), .COUNT_WIDTH(8)) u_dut_even (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in), .valid_in(valid_in),
        .ready_out(a_ready_out), .data_out(a_data_out), .parity_err(a_parity_err),
        .valid_out(a_valid_out), .ready_in(ready_in), .err_sticky(a_err_sticky),
        .err_count(a_err_count), .clr_count(clr_count)
    );

    parity_checker #(.DATA_WIDTH(8), .PARITY_TYPE(1), .COUNT_WIDTH(2)) u_dut_odd (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in), .valid_in(valid_in),
        .ready_out(b_ready_out), .data_out(b_data_out), .parity_err(b_parity_err),
        .valid_out(b_valid_out), .ready_in(ready_in), .err_sticky(b_err_sticky),
        .err_count(b_err_count), .clr_count(clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_data[i] = '0; m_err[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
        end
    endtask

    task automatic check_model();
        check_eq("valid_even",  {31'b0, a_valid_out},  {31'b0, m_valid[0]});
        check_eq("data_even",   {24'b0, a_data_out},   {24'b0, m_data[0]});
        check_eq("err_even",    {31'b0, a_parity_err}, {31'b0, m_err[0]});
        check_eq("count_even",  {24'b0, a_err_count},  m_cnt[0]);
        check_eq("sticky_even", {31'b0, a_err_sticky}, {31'b0, m_sticky[0]});
        check_eq("valid_odd",   {31'b0, b_valid_out},  {31'b0, m_valid[1]});
        check_eq("data_odd",    {24'b0, b_data_out},   {24'b0, m_data[1]});
        check_eq("err_odd",     {31'b0, b_parity_err}, {31'b0, m_err[1]});
        check_eq("count_odd",   {30'b0, b_err_count},  m_cnt[1]);
        check_eq("sticky_odd",  {31'b0, b_err_sticky}, {31'b0, m_sticky[1]});
    endtask

    // One clock of stimulus: drive, check ready_out, advance model, check registered outputs.
    task automatic cycle(input logic [7:0] d, input logic p, input logic v,
                         input logic r, input logic c);
        bit rdy [2];
        bit err;
        data_in = d; parity_in = p; valid_in = v; ready_in = r; clr_count = c;
        #1;
        for (int i = 0; i < 2; i++) rdy[i] = !m_valid[i] || r;
        check_eq("ready_out_even", {31'b0, a_ready_out}, {31'b0, rdy[0]});
        check_eq("ready_out_odd",  {31'b0, b_ready_out}, {31'b0, rdy[1]});
        for (int i = 0; i < 2; i++) begin
            err = ((($countones(d) + int'(p)) % 2) != PT[i]);
            if (v && rdy[i]) begin
                m_data[i] = d; m_err[i] = err; m_valid[i] = 1;
            end else if (m_valid[i] && r) begin
                m_valid[i] = 0;
            end
            if (c) begin
                m_cnt[i] = 0; m_sticky[i] = 0;
            end else if (v && rdy[i] && err) begin
                m_sticky[i] = 1;
                if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; data_in = '0; parity_in = 0; valid_in = 0; ready_in = 0; clr_count = 0;
        model_reset();
        #12;
        check_model();
        check_eq("reset_ready", {31'b0, a_ready_out}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Clean word, even parity
        cycle(8'hFF, 0, 1, 1, 0);
        check_eq("t1_data",  {24'b0, a_data_out}, 32'hFF);
        check_eq("t1_valid", {31'b0, a_valid_out}, 32'd1);
        check_eq("t1_err",   {31'b0, a_parity_err}, 32'd0);
        check_eq("t1_count", {24'b0, a_err_count}, 32'd0);

        // Same data, parity 1 then 0 back to back
        cycle(8'b01010100, 1, 1, 1, 0);
        check_eq("t2_err_even_a", {31'b0, a_parity_err}, 32'd0);
        check_eq("t2_err_odd_a",  {31'b0, b_parity_err}, 32'd1);
        cycle(8'b01010100, 0, 1, 1, 0);
        check_eq("t2_err_even_b", {31'b0, a_parity_err}, 32'd1);
        check_eq("t2_err_odd_b",  {31'b0, b_parity_err}, 32'd0);
        check_eq("t2_count",      {24'b0, a_err_count}, 32'd1);
        check_eq("t2_sticky",     {31'b0, a_err_sticky}, 32'd1);

        // Back-pressure: A5 held while 3C waits, then swap with no bubble
        cycle(8'hA5, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(8'h3C, 0, 1, 0, 0);
            check_eq("t3_ready_stall", {31'b0, a_ready_out}, 32'd0);
            check_eq("t3_data_hold",   {24'b0, a_data_out}, 32'hA5);
        end
        cycle(8'h3C, 0, 1, 1, 0);
        check_eq("t3_data_next",  {24'b0, a_data_out}, 32'h3C);
        check_eq("t3_valid_next", {31'b0, a_valid_out}, 32'd1);
        cycle(8'h00, 0, 0, 1, 0);

        // Saturation on the 2-bit counter, then clear beating an errored word
        cycle(8'h00, 0, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(8'h00, 0, 1, 1, 0);
            check_eq("t4_sat_count", {30'b0, b_err_count}, (k < 3) ? k + 1 : 3);
        end
        cycle(8'h00, 0, 1, 1, 1);
        check_eq("t4_clr_count",  {30'b0, b_err_count}, 32'd0);
        check_eq("t4_clr_sticky", {31'b0, b_err_sticky}, 32'd0);

        // Async reset during a stall with count 2
        cycle(8'h00, 0, 0, 1, 1);
        cycle(8'h01, 0, 1, 1, 0);
        cycle(8'h01, 0, 1, 1, 0);
        cycle(8'h01, 0, 1, 0, 0);
        check_eq("t5_pre_count", {24'b0, a_err_count}, 32'd2);
        check_eq("t5_pre_valid", {31'b0, a_valid_out}, 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_model();
        check_eq("t5_ready", {31'b0, a_ready_out}, 32'd1);
        valid_in = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h5A, 1, 1, 1, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            cycle(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_checker.md
# parity_checker

Receive-side companion to the parity generator. It accepts a data word plus its parity bit over a valid/ready stream, recomputes parity, and registers the word, a per-word error flag, a sticky error flag and a saturating error counter. It sits at the receiving end of any link that appends a parity bit with the generator, and uses the same DATA_WIDTH and PARITY_TYPE convention.

## Interface
- DATA_WIDTH, 8, width of data_in/data_out
- PARITY_TYPE, 0, 0 = even parity (XOR of data and parity bit is 0), 1 = odd parity (XOR of data and parity bit is 1); must match the generator
- COUNT_WIDTH, 8, width of err_count

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  DATA_WIDTH  received data word
- parity_in  in  1  received parity bit
- valid_in  in  1  data_in/parity_in valid this cycle
- ready_out  out  1  checker can accept a word this cycle
- data_out  out  DATA_WIDTH  registered data word
- parity_err  out  1  error flag for the word on data_out
- valid_out  out  1  data_out/parity_err valid
- ready_in  in  1  downstream accepts the output word this cycle
- err_sticky  out  1  set by any accepted errored word; held until clr_count
- err_count  out  COUNT_WIDTH  number of accepted errored words, saturating
- clr_count  in  1  synchronous clear of err_count and err_sticky

## Operation
- Expected parity: p_exp = ^data_in when PARITY_TYPE = 0, ~^data_in when PARITY_TYPE = 1. Error: err = parity_in != p_exp.
- Single output register stage holding data_out, parity_err and valid_out.
- ready_out = !valid_out || ready_in (combinational). An input transfer occurs when valid_in && ready_out. An output transfer occurs when valid_out && ready_in.
- On an input transfer: data_out <= data_in, parity_err <= err, valid_out <= 1.
- On an output transfer with no input transfer: valid_out <= 0. data_out and parity_err hold their last values (don't-care).
- Stall: while valid_out && !ready_in, data_out, parity_err and valid_out stay stable, and ready_out = 0.
- Simultaneous output and input transfer: the new word replaces the old one in the same edge, with no bubble. This sustains 1 word/cycle.
- Counter and sticky update only on an input transfer with err = 1:
  - err_count increments by 1 and saturates at 2^COUNT_WIDTH-1 with no wrap.
  - err_sticky <= 1.
- clr_count = 1 sets err_count <= 0 and err_sticky <= 0. This has priority over an increment in the same cycle, so that errored word is not counted. clr_count does not affect the data path.
- valid_in while ready_out = 0: no transfer. The source holds its word. No state changes.

## Timing
- Latency: a word accepted at edge N appears on data_out/valid_out/parity_err after edge N. parity_err is aligned with its word.
- err_count and err_sticky reflect an errored word from the same edge that loads it into the output stage.
- Reset values (asynchronous, immediate on rst assertion):
  - valid_out = 0
  - data_out = 0
  - parity_err = 0
  - err_sticky = 0
  - err_count = 0
  - ready_out = 1 while rst is high (derived from valid_out = 0)
- Reset mid-stall discards the held word. After rst deasserts, the first input transfer can occur at the next edge.
- No combinational path from valid_in to valid_out. The only combinational path is ready_in to ready_out.

## Test plan
- DATA_WIDTH=8, PARITY_TYPE=0; data_in=8'hFF, parity_in=0, valid_in=1, ready_in=1 -> next cycle data_out=8'hFF, valid_out=1, parity_err=0, err_count=0.
- PARITY_TYPE=0; data_in=8'b01010100 with parity_in=1, then with parity_in=0 on back-to-back cycles -> parity_err 0 then 1 on consecutive cycles; err_count=1, err_sticky=1.
- PARITY_TYPE=1; data_in=8'b01010100, parity_in=0 -> parity_err=0. With parity_in=1 -> parity_err=1.
- Back-pressure: load 8'hA5, hold ready_in=0 for 3 cycles while presenting 8'h3C -> ready_out=0, data_out stays 8'hA5. Raise ready_in -> 8'hA5 transfers, and 8'h3C loads on the same edge with no gap.
- COUNT_WIDTH=2; 5 consecutive errored words -> err_count goes 1,2,3,3,3. Then clr_count=1 in the same cycle as a sixth errored word -> err_count=0, err_sticky=0.
- Assert rst asynchronously during a stall with valid_out=1 and err_count=2 -> all outputs zero immediately, before the next clk edge; ready_out=1.
